// File: rtl/fpcvt_pipe.sv
// -----------------------------------------------------------------------------
// fpcvt_pipe
//
// Three-stage pipelined converter from a two's-complement sample to a small
// floating-point form (sign, exponent, significand) with value
// out_f * 2^out_e. Each sample carries its own rounding mode (truncate or
// round half up). A sample whose result cannot be represented is clamped to
// the largest magnitude and flagged.
//
//   Stage 1: sign/magnitude split; the most-negative input is clamped.
//   Stage 2: leading-one search, normalise, extract round and sticky bits.
//   Stage 3: optional round-half-up, exponent bump on carry, saturation.
//
// The pipe moves as a unit: every stage advances when the output register
// is empty or the consumer is taking its value. Bubbles stay in place.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid_i     input sample valid
//   in_ready_o     converter accepts a sample this cycle
//   in_data_i      two's-complement sample, IN_W bits
//   in_rnd_i       rounding mode for this sample: 0 truncate, 1 round half up
//   out_valid_o    result valid
//   out_ready_i    downstream accepts the result
//   out_s_o        sign
//   out_e_o        exponent, EXP_W bits
//   out_f_o        significand, MAN_W bits
//   out_sat_o      result clamped to the largest magnitude
//   out_inexact_o  nonzero magnitude bits were discarded, or result saturated
// -----------------------------------------------------------------------------
module fpcvt_pipe #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_rnd_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_s_o,
    output logic [EXP_W-1:0] out_e_o,
    output logic [MAN_W-1:0] out_f_o,
    output logic             out_sat_o,
    output logic             out_inexact_o
);

    localparam int          M      = IN_W - 1;           // magnitude width
    localparam int          EW     = $clog2(M + 1);      // holds any bit index of the magnitude
    localparam logic [31:0] EMAX_U = 32'((1 << EXP_W) - 1);

    // Whole pipe advances together.
    logic adv;

    // ---------------- Stage 1 state ----------------
    logic             s1_valid_q;
    logic             s1_s_q,   s1_s_d;
    logic [M-1:0]     s1_mag_q, s1_mag_d;
    logic             s1_sat_q, s1_sat_d;
    logic             s1_rnd_q;

    // ---------------- Stage 2 state ----------------
    logic             s2_valid_q;
    logic             s2_s_q;
    logic [EXP_W-1:0] s2_e_q,      s2_e_d;
    logic [MAN_W-1:0] s2_f_q,      s2_f_d;
    logic             s2_r_q,      s2_r_d;
    logic             s2_sticky_q, s2_sticky_d;
    logic             s2_sat_q,    s2_sat_d;
    logic             s2_rnd_q;

    // ---------------- Stage 3 (output) state ----------------
    logic             s3_valid_q;
    logic             s3_s_q;
    logic [EXP_W-1:0] s3_e_q,       s3_e_d;
    logic [MAN_W-1:0] s3_f_q,       s3_f_d;
    logic             s3_sat_q,     s3_sat_d;
    logic             s3_inexact_q, s3_inexact_d;

    assign adv        = ~s3_valid_q | out_ready_i;
    assign in_ready_o = adv;

    // ---------------- Stage 1: sign / magnitude ----------------
    logic [IN_W-1:0] neg_data;

    always_comb begin
        neg_data = ~in_data_i + {{(IN_W-1){1'b0}}, 1'b1};
        s1_s_d   = in_data_i[IN_W-1];
        s1_sat_d = 1'b0;
        s1_mag_d = in_data_i[M-1:0];
        if (s1_s_d) begin
            // The most-negative value has no positive twin in M bits.
            if (in_data_i == {1'b1, {M{1'b0}}}) begin
                s1_mag_d = '1;
                s1_sat_d = 1'b1;
            end else begin
                s1_mag_d = neg_data[M-1:0];
            end
        end
    end

    // ---------------- Stage 2: normalise ----------------
    logic [EW-1:0] lead_pos;
    logic [EW-1:0] e_norm;
    logic [M-1:0]  shifted;
    logic [M-1:0]  sticky_mask;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        lead_pos    = '0;
        e_norm      = '0;
        shifted     = '0;
        sticky_mask = '0;
        s2_e_d      = '0;
        s2_f_d      = s1_mag_q[MAN_W-1:0];
        s2_r_d      = 1'b0;
        s2_sticky_d = 1'b0;
        s2_sat_d    = s1_sat_q;

        // Last match wins, so this yields the index of the highest set bit.
        for (int i = 0; i < M; i++) begin
            if (s1_mag_q[i]) lead_pos = EW'(i);
        end

        // A leading one at or above bit MAN_W means the magnitude does not fit
        // the significand directly (equivalently lz < M - MAN_W).
        if (lead_pos >= EW'(MAN_W)) begin
            e_norm      = lead_pos - EW'(MAN_W - 1);
            // Keep one extra bit below the significand: that is the round bit.
            shifted     = s1_mag_q >> (e_norm - EW'(1));
            sticky_mask = (M'(1) << (e_norm - EW'(1))) - M'(1);
            s2_f_d      = shifted[MAN_W:1];
            s2_r_d      = shifted[0];
            s2_sticky_d = |(s1_mag_q & sticky_mask);
            s2_e_d      = EXP_W'(e_norm);
            if (32'(e_norm) > EMAX_U) s2_sat_d = 1'b1;
        end
    end

    // ---------------- Stage 3: round / saturate ----------------
    logic [MAN_W:0] f_sum;
    logic [EXP_W:0] e_inc;

    always_comb begin
        f_sum    = {1'b0, s2_f_q} + {{MAN_W{1'b0}}, 1'b1};
        e_inc    = {1'b0, s2_e_q} + {{EXP_W{1'b0}}, 1'b1};
        s3_e_d   = s2_e_q;
        s3_f_d   = s2_f_q;
        s3_sat_d = s2_sat_q;

        if (s2_rnd_q && s2_r_q) begin
            if (f_sum[MAN_W]) begin
                // Significand wrapped: renormalise to 100..0 and bump exponent.
                s3_f_d = {1'b1, {(MAN_W-1){1'b0}}};
                s3_e_d = e_inc[EXP_W-1:0];
                // EMAX is all ones, so a carry out of the exponent means > EMAX.
                if (e_inc[EXP_W]) s3_sat_d = 1'b1;
            end else begin
                s3_f_d = f_sum[MAN_W-1:0];
            end
        end

        if (s3_sat_d) begin
            s3_e_d = '1;
            s3_f_d = '1;
        end

        s3_inexact_d = s2_r_q | s2_sticky_q | s3_sat_d;
    end

    // ---------------- Pipeline registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before this edge.
    // NOTE: data registers are reset along with the valids because the
    // output fields are architecturally visible as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_s_q       <= 1'b0;
            s1_mag_q     <= '0;
            s1_sat_q     <= 1'b0;
            s1_rnd_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_s_q       <= 1'b0;
            s2_e_q       <= '0;
            s2_f_q       <= '0;
            s2_r_q       <= 1'b0;
            s2_sticky_q  <= 1'b0;
            s2_sat_q     <= 1'b0;
            s2_rnd_q     <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_s_q       <= 1'b0;
            s3_e_q       <= '0;
            s3_f_q       <= '0;
            s3_sat_q     <= 1'b0;
            s3_inexact_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q   <= in_valid_i;
            s1_s_q       <= s1_s_d;
            s1_mag_q     <= s1_mag_d;
            s1_sat_q     <= s1_sat_d;
            s1_rnd_q     <= in_rnd_i;
            s2_valid_q   <= s1_valid_q;
            s2_s_q       <= s1_s_q;
            s2_e_q       <= s2_e_d;
            s2_f_q       <= s2_f_d;
            s2_r_q       <= s2_r_d;
            s2_sticky_q  <= s2_sticky_d;
            s2_sat_q     <= s2_sat_d;
            s2_rnd_q     <= s1_rnd_q;
            s3_valid_q   <= s2_valid_q;
            s3_s_q       <= s2_s_q;
            s3_e_q       <= s3_e_d;
            s3_f_q       <= s3_f_d;
            s3_sat_q     <= s3_sat_d;
            s3_inexact_q <= s3_inexact_d;
        end
    end

    assign out_valid_o   = s3_valid_q;
    assign out_s_o       = s3_s_q;
    assign out_e_o       = s3_e_q;
    assign out_f_o       = s3_f_q;
    assign out_sat_o     = s3_sat_q;
    assign out_inexact_o = s3_inexact_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpcvt_pipe
//
// Directed bench for fpcvt_pipe. Two instances: the default geometry
// (12/3/4) and a wide-significand variant (16/3/6) whose maximum exponent
// exceeds EMAX. Results are compared as packed {s, e, f, sat, inexact}.
// -----------------------------------------------------------------------------
module tb_fpcvt_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- Default instance ----------------
    logic        in_valid, in_ready, in_rnd;
    logic [11:0] in_data;
    logic        out_valid, out_ready, out_s, out_sat, out_inexact;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic [9:0]  res1;
    assign res1 = {out_s, out_e, out_f, out_sat, out_inexact};

    fpcvt_pipe #(.IN_W(12), .EXP_W(3), .MAN_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .in_rnd_i      (in_rnd),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_s_o       (out_s),
        .out_e_o       (out_e),
        .out_f_o       (out_f),
        .out_sat_o     (out_sat),
        .out_inexact_o (out_inexact)
    );

    // ---------------- Wide variant ----------------
    logic        in_valid2, in_ready2, in_rnd2;
    logic [15:0] in_data2;
    logic        out_valid2, out_ready2, out_s2, out_sat2, out_inexact2;
    logic [2:0]  out_e2;
    logic [5:0]  out_f2;
    logic [11:0] res2;
    assign res2 = {out_s2, out_e2, out_f2, out_sat2, out_inexact2};

    fpcvt_pipe #(.IN_W(16), .EXP_W(3), .MAN_W(6)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid2),
        .in_ready_o    (in_ready2),
        .in_data_i     (in_data2),
        .in_rnd_i      (in_rnd2),
        .out_valid_o   (out_valid2),
        .out_ready_i   (out_ready2),
        .out_s_o       (out_s2),
        .out_e_o       (out_e2),
        .out_f_o       (out_f2),
        .out_sat_o     (out_sat2),
        .out_inexact_o (out_inexact2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Vector table, expected = {s, e[2:0], f[3:0], sat, inexact}.
    logic [11:0] vd [8];
    logic        vr [8];
    logic [9:0]  ve [8];

    // One isolated conversion on the default instance, checking latency 3.
    // Called just after a rising edge.
    task automatic convert1(input string tag, input logic [11:0] d, input logic r,
                            input logic [9:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_rnd    = r;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_rnd   = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(res1), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic convert2(input string tag, input logic [15:0] d, input logic r,
                            input logic [11:0] exp);
        in_valid2 = 1'b1;
        in_data2  = d;
        in_rnd2   = r;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid2), 32'd1);
        check(tag, 32'(res2), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vd = '{12'h07D, 12'h07D, 12'h800, 12'h7FF, 12'h7FF, 12'hFFB, 12'h000, 12'h0C8};
        vr = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1,    1'b1};
        ve = '{10'b0_100_1000_0_1,   // 125 rounded: 15+1 carries -> E=4, F=8
               10'b0_011_1111_0_1,   // 125 truncated
               10'b1_111_1111_1_1,   // -2048 clamps
               10'b0_111_1111_1_1,   // 2047 rounded: exponent overflow
               10'b0_111_1111_0_1,   // 2047 truncated fits at EMAX
               10'b1_000_0101_0_0,   // -5 exact
               10'b0_000_0000_0_0,   // zero
               10'b0_100_1101_0_1};  // 200 rounded: F 12 -> 13

        rst_n      = 1'b0;
        in_valid   = 1'b0; in_data  = '0; in_rnd  = 1'b0; out_ready  = 1'b0;
        in_valid2  = 1'b0; in_data2 = '0; in_rnd2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_fields",    32'(res1),      32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single conversions.
        for (int i = 0; i < 8; i++)
            convert1($sformatf("vec%0d", i), vd[i], vr[i], ve[i]);

        // Streaming with a 4-cycle stall.
        begin
            int         sent      = 0;
            int         got       = 0;
            int         stalls    = 0;
            logic       stall_prv = 1'b0;
            logic       accepted;
            logic [9:0] held      = '0;
            for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
                out_ready = !(cyc >= 4 && cyc < 8);
                in_valid  = (sent < 8);
                in_data   = (sent < 8) ? vd[sent] : 12'h000;
                in_rnd    = (sent < 8) ? vr[sent] : 1'b0;
                @(negedge clk);
                if (out_valid && !out_ready) begin
                    stalls++;
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    if (stall_prv) check("stall_hold", 32'(res1), 32'(held));
                    held      = res1;
                    stall_prv = 1'b1;
                end else begin
                    stall_prv = 1'b0;
                end
                if (out_valid && out_ready) begin
                    check($sformatf("stream%0d", got), 32'(res1), 32'(ve[got]));
                    got++;
                end
                accepted = in_valid && in_ready;
                @(posedge clk); #1;
                if (accepted) sent++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("stream_count",  32'(got),    32'd8);
            check("stream_stalls", 32'(stalls), 32'd4);
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset with three samples in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vd[i];
            in_rnd  = vr[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("flight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fields",    32'(res1),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        convert1("post_rst", 12'h0C8, 1'b1, 10'b0_100_1101_0_1);

        // Wide variant: {s, e[2:0], f[5:0], sat, inexact}.
        convert2("wide_sat",   16'h4000, 1'b0, 12'b0_111_111111_1_1);
        convert2("wide_exact", 16'h00C8, 1'b1, 12'b0_010_110010_0_0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
